fdiv_seq: RTL

Programmable tone/rate sequencer that drives the 32-bit divisor input of the team's programmable frequency divider. It holds a small table of (divisor, duration) steps written over a config port. On `start` it plays the steps in order, presenting each divisor for an exact number of clock cycles, with optional looping, rests and abort. It sits between the lab's control logic (switches/FSM) and the divider instance; the divider output itself is not routed through this block.

---
 rtl/fdiv_seq_pkg.sv | 20 ++
 rtl/fdiv_seq_tick_gen.sv | 31 +++
 rtl/fdiv_seq.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/fdiv_seq_pkg.sv
// Shared definitions for the tone/rate sequencer: FSM encoding and table markers.
package fdiv_seq_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PLAY = 1'b1
    } state_t;

    // A divisor of zero means "rest": the divider output is gated off.
    localparam logic [31:0] REST_DIVN = 32'd0;

    // A duration of zero terminates the sequence at that entry.
    localparam int unsigned END_DUR = 0;

    // Width of a 0..td-1 counter, never narrower than one bit.
    function automatic int tick_width(input int td);
        return (td > 1) ? $clog2(td) : 1;
    endfunction

endpackage

// File: rtl/fdiv_seq_tick_gen.sv
// Duration-unit prescaler: counts 0..TICK_DIV-1 and flags the wrap cycle.
module tick_gen
    import fdiv_seq_pkg::*;
#(
    parameter int TICK_DIV = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    output logic o_tick
);

    localparam int TW = tick_width(TICK_DIV);
    localparam logic [TW-1:0] LAST = TW'(TICK_DIV - 1);

    logic [TW-1:0] r_cnt;

    // Free-running prescaler, restarted at every step entry and while idle.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_cnt <= {TW{1'b0}};
        end else if (r_cnt == LAST) begin
            r_cnt <= {TW{1'b0}};
        end else begin
            r_cnt <= r_cnt + TW'(1);
        end
    end

    assign o_tick = (r_cnt == LAST);

endmodule

// File: rtl/fdiv_seq.sv
// Programmable tone/rate sequencer feeding the divisor of the frequency divider.
// Plays a table of (divisor, duration) steps; every output is registered.
module fdiv_seq
    import fdiv_seq_pkg::*;
#(
    parameter  int STEPS    = 8,
    parameter  int TICK_DIV = 50000,
    parameter  int DUR_W    = 16,
    localparam int AW       = $clog2(STEPS)
) (
    input  logic             fin,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [AW-1:0]    cfg_addr,
    input  logic [31:0]      cfg_divn,
    input  logic [DUR_W-1:0] cfg_dur,
    input  logic             start,
    input  logic             stop,
    input  logic             loop,
    output logic [31:0]      DIVN,
    output logic             mute,
    output logic [AW-1:0]    step,
    output logic             busy,
    output logic             done
);

    localparam logic [DUR_W-1:0] END_D = DUR_W'(END_DUR);

    logic [31:0]      r_tbl_divn [STEPS];
    logic [DUR_W-1:0] r_tbl_dur  [STEPS];

    state_t           r_state;
    state_t           w_state_nxt;
    logic [DUR_W-1:0] r_dur;
    logic [DUR_W-1:0] r_unit;
    logic             w_tick;
    logic             w_last;
    logic             w_has_next;
    logic             w_load;
    logic [AW-1:0]    w_load_idx;
    logic [AW-1:0]    w_next_idx;
    logic             w_done_nxt;
    logic             w_clr;

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .i_clk  (fin),
        .i_rst  (rst),
        .i_clr  (w_clr),
        .o_tick (w_tick)
    );

    // Step table: writable at any time, deliberately not reset.
    always_ff @(posedge fin) begin
        if (cfg_we) begin
            r_tbl_divn[cfg_addr] <= cfg_divn;
            r_tbl_dur[cfg_addr]  <= cfg_dur;
        end
    end

    assign w_next_idx = step + AW'(1);
    assign w_has_next = (step != AW'(STEPS - 1)) && (r_tbl_dur[w_next_idx] != END_D);
    // r_dur is at least 1 in PLAY, so dur-1 is the final unit of the step.
    assign w_last     = w_tick && (r_unit == (r_dur - DUR_W'(1)));
    assign w_clr      = w_load || (w_state_nxt != ST_PLAY);

    // Next-state logic: start/stop/advance/loop decisions and done request.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_load_idx  = {AW{1'b0}};
        w_done_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start && !stop) begin
                    if (r_tbl_dur[0] != END_D) begin
                        w_state_nxt = ST_PLAY;
                        w_load      = 1'b1;
                    end else begin
                        w_done_nxt = 1'b1;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_PLAY: begin
                if (stop) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_last) begin
                    if (w_has_next) begin
                        w_load     = 1'b1;
                        w_load_idx = w_next_idx;
                    end else if (loop && (r_tbl_dur[0] != END_D)) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_done_nxt  = 1'b1;
                    end
                end else begin
                    w_state_nxt = ST_PLAY;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register plus registered outputs and the duration-unit counter.
    always_ff @(posedge fin) begin
        if (rst) begin
            r_state <= ST_IDLE;
            DIVN    <= REST_DIVN;
            mute    <= 1'b1;
            step    <= {AW{1'b0}};
            busy    <= 1'b0;
            done    <= 1'b0;
            r_dur   <= {DUR_W{1'b0}};
            r_unit  <= {DUR_W{1'b0}};
        end else begin
            r_state <= w_state_nxt;
            done    <= w_done_nxt;
            busy    <= (w_state_nxt == ST_PLAY);
            if (w_load) begin
                DIVN   <= r_tbl_divn[w_load_idx];
                mute   <= (r_tbl_divn[w_load_idx] == REST_DIVN);
                step   <= w_load_idx;
                r_dur  <= r_tbl_dur[w_load_idx];
                r_unit <= {DUR_W{1'b0}};
            end else if (w_state_nxt != ST_PLAY) begin
                DIVN   <= REST_DIVN;
                mute   <= 1'b1;
                step   <= {AW{1'b0}};
                r_dur  <= {DUR_W{1'b0}};
                r_unit <= {DUR_W{1'b0}};
            end else if (w_tick) begin
                r_unit <= r_unit + DUR_W'(1);
            end
        end
    end

endmodule
